// File: rtl/key_conditioner.sv
// Pushbutton front end: 2-flop sync, polarity normalise, debounce, press/release strobes, auto-repeat.
// Latency DEBOUNCE_CYCLES+2 edges from pin change to key_level/strobe; no backpressure, strobes are one cycle.
module key_conditioner #(
    parameter int N_KEYS          = 3,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_pulse,
    output logic [N_KEYS-1:0] key_release,
    output logic              any_pulse
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} rpt_state_e;

    logic [N_KEYS-1:0] key_norm;
    logic [N_KEYS-1:0] sync0_q;
    logic [N_KEYS-1:0] sync1_q;

    assign key_norm = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= key_norm;
            sync1_q <= sync0_q;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          level_q, level_d;
        logic          pulse_q, pulse_d;
        logic          release_q, release_d;
        logic          press_acc, release_acc;
        rpt_state_e    state_q, state_d;

        // Any sample agreeing with the accepted level restarts the stability count.
        always_comb begin
            dcnt_d      = '0;
            level_d     = level_q;
            press_acc   = 1'b0;
            release_acc = 1'b0;
            if (sync1_q[i] != level_q) begin
                if (dcnt_q == DEB_LAST) begin
                    level_d     = ~level_q;
                    press_acc   = ~level_q;
                    release_acc = level_q;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
        end

        // Release pre-empts any repeat strobe that would land on the same edge.
        always_comb begin
            state_d   = state_q;
            rcnt_d    = rcnt_q;
            pulse_d   = 1'b0;
            release_d = release_acc;
            if (release_acc) begin
                state_d = IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (press_acc) begin
                            pulse_d = 1'b1;
                            rcnt_d  = '0;
                            state_d = repeat_en[i] ? HELD : IDLE;
                        end
                    end
                    HELD: begin
                        if (rcnt_q == DLY_LAST) begin
                            pulse_d = 1'b1;
                            rcnt_d  = '0;
                            state_d = REPEAT;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rcnt_q == PER_LAST) begin
                            pulse_d = 1'b1;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dcnt_q    <= '0;
                rcnt_q    <= '0;
                level_q   <= 1'b0;
                pulse_q   <= 1'b0;
                release_q <= 1'b0;
                state_q   <= IDLE;
            end else begin
                dcnt_q    <= dcnt_d;
                rcnt_q    <= rcnt_d;
                level_q   <= level_d;
                pulse_q   <= pulse_d;
                release_q <= release_d;
                state_q   <= state_d;
            end
        end

        assign key_level[i]   = level_q;
        assign key_pulse[i]   = pulse_q;
        assign key_release[i] = release_q;
    end

    assign any_pulse = |key_pulse;

endmodule
